// File: rtl/l1_dcache_dm.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 128-bit lines.
// Optional performance counters are enabled by defining L1_DCACHE_PERF_EN.
module l1_dcache_dm #(
    parameter int SETS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
`ifdef L1_DCACHE_PERF_EN
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count,
    output logic [15:0]  wb_count,
`endif
    input  logic         pmem_resp
);

    localparam int IDX = $clog2(SETS);
    localparam int TAG = 12 - IDX;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [127:0]    data_q [SETS];
    logic [TAG-1:0]  tag_q  [SETS];
    logic [SETS-1:0] valid_q;
    logic [SETS-1:0] dirty_q;

    logic [TAG-1:0]  tag_s;
    logic [IDX-1:0]  idx_s;
    logic [2:0]      word_s;
    logic [127:0]    line_s;
    logic            hit_s;
    logic            req_s;
    logic            resp_s;
    logic            wr_hit_s;
    logic            fill_done_s;
    logic            evict_done_s;
    logic            unused_addr_bit_s;

    // Merge the enabled byte lanes of a 16-bit write into one word of a line.
    function automatic logic [127:0] write_word(input logic [127:0] line,
                                                input logic [2:0]   word,
                                                input logic [15:0]  wdata,
                                                input logic [1:0]   be);
        logic [127:0] res;
        res = line;
        if (be[0]) begin
            res[{word, 4'b0000} +: 8] = wdata[7:0];
        end else begin
            res[{word, 4'b0000} +: 8] = line[{word, 4'b0000} +: 8];
        end
        if (be[1]) begin
            res[{word, 4'b1000} +: 8] = wdata[15:8];
        end else begin
            res[{word, 4'b1000} +: 8] = line[{word, 4'b1000} +: 8];
        end
        return res;
    endfunction

    assign tag_s             = mem_address[15:4+IDX];
    assign idx_s             = mem_address[3+IDX:4];
    assign word_s            = mem_address[3:1];
    assign unused_addr_bit_s = mem_address[0];
    assign line_s            = data_q[idx_s];
    assign hit_s             = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
    assign req_s             = mem_read || mem_write;
    assign resp_s            = (state_q == ST_IDLE) && req_s && hit_s;
    assign wr_hit_s          = resp_s && mem_write;
    assign fill_done_s       = (state_q == ST_ALLOCATE) && pmem_resp;
    assign evict_done_s      = (state_q == ST_WRITEBACK) && pmem_resp;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a miss evicts first only when the victim line is dirty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s && !hit_s) begin
                    if (dirty_q[idx_s]) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        state_d = ST_ALLOCATE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                if (pmem_resp) begin
                    state_d = ST_ALLOCATE;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_ALLOCATE: begin
                if (pmem_resp) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ALLOCATE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode for the CPU and physical-memory sides.
    always_comb begin
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = {128{1'b0}};
        case (state_q)
            ST_IDLE: begin
                mem_resp = resp_s;
            end
            ST_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[idx_s], idx_s, 4'b0000};
                pmem_wdata   = line_s;
            end
            ST_ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[15:4], 4'b0000};
            end
            default: begin
                mem_resp = 1'b0;
            end
        endcase
        if (hit_s) begin
            mem_rdata = line_s[{word_s, 4'b0000} +: 16];
        end else begin
            mem_rdata = 16'h0000;
        end
    end

    // Line data and tag storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (fill_done_s) begin
            data_q[idx_s] <= pmem_rdata;
            tag_q[idx_s]  <= tag_s;
        end else if (wr_hit_s) begin
            data_q[idx_s] <= write_word(line_s, word_s, mem_wdata, mem_byte_enable);
        end
    end

    // Valid and dirty bits; a masked-off write still marks the line dirty.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= {SETS{1'b0}};
            dirty_q <= {SETS{1'b0}};
        end else if (fill_done_s) begin
            valid_q[idx_s] <= 1'b1;
            dirty_q[idx_s] <= 1'b0;
        end else if (evict_done_s) begin
            dirty_q[idx_s] <= 1'b0;
        end else if (wr_hit_s) begin
            dirty_q[idx_s] <= 1'b1;
        end
    end

`ifdef L1_DCACHE_PERF_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;
    logic [15:0] wb_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
            wb_cnt_q   <= 16'h0000;
        end else begin
            if (resp_s && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if ((state_q == ST_IDLE) && (state_d != ST_IDLE) && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
            if (evict_done_s && (wb_cnt_q != 16'hFFFF)) begin
                wb_cnt_q <= wb_cnt_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
    assign wb_count   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_l1_dcache_dm.sv
// Directed bench for l1_dcache_dm (SETS=8): fills, hits, write merges, evictions, reset mid-fill.
module tb_l1_dcache_dm;

    logic         clk;
    logic         reset;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
`ifdef L1_DCACHE_PERF_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
    logic [15:0]  wb_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [127:0] line1;
    logic [127:0] line1_mod;
    logic [127:0] line2;
    logic [127:0] line3;
    logic [127:0] line4;

    l1_dcache_dm #(.SETS(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
`ifdef L1_DCACHE_PERF_EN
        .hit_count       (hit_count),
        .miss_count      (miss_count),
        .wb_count        (wb_count),
`endif
        .pmem_resp       (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a physical request, check it, then answer it for one cycle.
    task automatic serve(input string tag, input logic exp_wr, input logic [15:0] exp_addr,
                         input logic [127:0] exp_wdata, input logic [127:0] fill);
        int n;
        n = 0;
        while (!(pmem_read || pmem_write) && (n < 20)) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, " req"}, {127'd0, (pmem_read || pmem_write)}, 128'd1);
        chk({tag, " rd"}, {127'd0, pmem_read}, {127'd0, !exp_wr});
        chk({tag, " wr"}, {127'd0, pmem_write}, {127'd0, exp_wr});
        chk({tag, " addr"}, {112'd0, pmem_address}, {112'd0, exp_addr});
        if (exp_wr) begin
            chk({tag, " wdata"}, pmem_wdata, exp_wdata);
        end
        pmem_rdata = fill;
        pmem_resp  = 1'b1;
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = 128'd0;
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [1:0] be, input logic [15:0] wd);
        @(negedge clk);
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_byte_enable = be;
        mem_wdata       = wd;
        #1;
    endtask

    initial begin
        line1     = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'hCAFE, 16'hBEEF};
        line1_mod = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'hCAFE, 16'hBE34};
        line2     = {16'h0707, 16'h0606, 16'h0505, 16'h0404, 16'h0303, 16'h0202, 16'h5A5A, 16'hA5A5};
        line3     = {16'h1818, 16'h1717, 16'h1616, 16'h1515, 16'h1414, 16'h1313, 16'h1212, 16'hD00D};
        line4     = {16'h2828, 16'h2727, 16'h2626, 16'h2525, 16'h2424, 16'h2323, 16'h2222, 16'hF00D};

        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = 16'h0000;
        mem_byte_enable = 2'b00; mem_wdata = 16'h0000; pmem_rdata = 128'd0; pmem_resp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst mem_resp", {127'd0, mem_resp}, 128'd0);
        chk("rst pmem_read", {127'd0, pmem_read}, 128'd0);
        chk("rst pmem_write", {127'd0, pmem_write}, 128'd0);
        chk("rst pmem_address", {112'd0, pmem_address}, 128'd0);
        chk("rst mem_rdata", {112'd0, mem_rdata}, 128'd0);

        // Clean miss on 0x0040.
        drive(1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000);
        chk("t1 miss resp", {127'd0, mem_resp}, 128'd0);
        serve("t1 fill", 1'b0, 16'h0040, 128'd0, line1);
        chk("t1 resp", {127'd0, mem_resp}, 128'd1);
        chk("t1 rdata", {112'd0, mem_rdata}, {112'd0, 16'hBEEF});
        chk("t1 no refill", {127'd0, pmem_read}, 128'd0);

        // Hit on another word of the same line.
        drive(1'b1, 1'b0, 16'h0042, 2'b00, 16'h0000);
        chk("t2 resp", {127'd0, mem_resp}, 128'd1);
        chk("t2 rdata", {112'd0, mem_rdata}, {112'd0, 16'hCAFE});
        chk("t2 pmem idle", {126'd0, pmem_read, pmem_write}, 128'd0);

        // Low-byte write hit, then reread.
        drive(1'b0, 1'b1, 16'h0040, 2'b01, 16'h1234);
        chk("t3 wr resp", {127'd0, mem_resp}, 128'd1);
        drive(1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000);
        chk("t3 rd resp", {127'd0, mem_resp}, 128'd1);
        chk("t3 rdata", {112'd0, mem_rdata}, {112'd0, 16'hBE34});

        // Conflict miss on a dirty line: evict then fill.
        drive(1'b1, 1'b0, 16'h00C0, 2'b00, 16'h0000);
        chk("t4 miss resp", {127'd0, mem_resp}, 128'd0);
        serve("t4 wb", 1'b1, 16'h0040, line1_mod, 128'd0);
        serve("t4 fill", 1'b0, 16'h00C0, 128'd0, line2);
        chk("t4 resp", {127'd0, mem_resp}, 128'd1);
        chk("t4 rdata", {112'd0, mem_rdata}, {112'd0, 16'hA5A5});

        // Read and write together: old word returned, high byte merged.
        drive(1'b1, 1'b1, 16'h00C2, 2'b10, 16'h7700);
        chk("rw resp", {127'd0, mem_resp}, 128'd1);
        chk("rw rdata old", {112'd0, mem_rdata}, {112'd0, 16'h5A5A});
        drive(1'b1, 1'b0, 16'h00C2, 2'b00, 16'h0000);
        chk("rw reread", {112'd0, mem_rdata}, {112'd0, 16'h775A});

        // Reset in the middle of a fill.
        drive(1'b1, 1'b0, 16'h0100, 2'b00, 16'h0000);
        chk("t5 miss resp", {127'd0, mem_resp}, 128'd0);
        @(negedge clk);
        #1;
        chk("t5 filling", {127'd0, pmem_read}, 128'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t5 rd dropped", {127'd0, pmem_read}, 128'd0);
        chk("t5 wr low", {127'd0, pmem_write}, 128'd0);
        chk("t5 no resp", {127'd0, mem_resp}, 128'd0);
        serve("t5 refill", 1'b0, 16'h0100, 128'd0, line3);
        chk("t5 resp", {127'd0, mem_resp}, 128'd1);
        chk("t5 rdata", {112'd0, mem_rdata}, {112'd0, 16'hD00D});

        // Reset also dropped the dirty 0x00C0 line: plain fill, no eviction.
        drive(1'b1, 1'b0, 16'h00C0, 2'b00, 16'h0000);
        chk("inv miss resp", {127'd0, mem_resp}, 128'd0);
        serve("inv fill", 1'b0, 16'h00C0, 128'd0, line2);
        chk("inv rdata", {112'd0, mem_rdata}, {112'd0, 16'hA5A5});

        // Empty byte mask still completes and dirties the line.
        drive(1'b0, 1'b1, 16'h0100, 2'b00, 16'hFFFF);
        chk("be0 resp", {127'd0, mem_resp}, 128'd1);
        drive(1'b1, 1'b0, 16'h0180, 2'b00, 16'h0000);
        chk("be0 miss resp", {127'd0, mem_resp}, 128'd0);
        serve("be0 wb", 1'b1, 16'h0100, line3, 128'd0);
        serve("be0 fill", 1'b0, 16'h0180, 128'd0, line4);
        chk("be0 resp", {127'd0, mem_resp}, 128'd1);
        chk("be0 rdata", {112'd0, mem_rdata}, {112'd0, 16'hF00D});

        drive(1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);
        chk("idle resp", {127'd0, mem_resp}, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
